// File: rtl/tree_node_dispatch.sv
`timescale 1ns/1ps
// Interior node of the generated module tree: dispatches upstream requests to one of
// NUM_CHILDREN children under per-child credit limits and round-robin merges their responses.
module tree_node_dispatch #(
  parameter int NUM_CHILDREN = 5,
  parameter int DATA_W       = 16,
  parameter int CREDITS      = 4,
  parameter int IDX_W        = $clog2(NUM_CHILDREN),
  parameter int CNT_W        = $clog2(CREDITS + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [IDX_W-1:0]             req_child_i,
  input  logic [DATA_W-1:0]            req_data_i,
  output logic [NUM_CHILDREN-1:0]      child_valid_o,
  input  logic [NUM_CHILDREN-1:0]      child_ready_i,
  output logic [DATA_W-1:0]            child_data_o,
  input  logic [NUM_CHILDREN-1:0]      rsp_valid_i,
  output logic [NUM_CHILDREN-1:0]      rsp_ready_o,
  input  logic [NUM_CHILDREN*DATA_W-1:0] rsp_data_i,
  output logic                         up_valid_o,
  input  logic                         up_ready_i,
  output logic [DATA_W-1:0]            up_data_o,
  output logic [IDX_W-1:0]             up_child_o,
  output logic                         busy_o,
  output logic [1:0]                   err_o
);

  logic                    stageValid_q, stageValid_d;
  logic [IDX_W-1:0]        stageChild_q, stageChild_d;
  logic [DATA_W-1:0]       stageData_q, stageData_d;
  logic [CNT_W-1:0]        creditCnt_q [NUM_CHILDREN];
  logic [CNT_W-1:0]        creditCnt_d [NUM_CHILDREN];
  logic [IDX_W-1:0]        rrPtr_q, rrPtr_d;
  logic                    upValid_q, upValid_d;
  logic [DATA_W-1:0]       upData_q, upData_d;
  logic [IDX_W-1:0]        upChild_q, upChild_d;
  logic [1:0]              err_q, err_d;

  logic                    reqLegal, stageReady, creditOk, reqReady, reqAccept, reqLoad;
  logic                    canGrant, grantValid, anyCredit;
  logic [IDX_W-1:0]        grantIdx;
  logic [DATA_W-1:0]       grantData;
  logic [NUM_CHILDREN-1:0] grantOneHot;
  logic [NUM_CHILDREN-1:0] incMask;

  // Illegal targets bypass the credit check so they can be accepted and dropped.
  always_comb begin
    reqLegal   = (int'(req_child_i) < NUM_CHILDREN);
    stageReady = !stageValid_q;
    creditOk   = 1'b1;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      if (stageValid_q && int'(stageChild_q) == i && child_ready_i[i]) begin
        stageReady = 1'b1;
      end
      if (reqLegal && int'(req_child_i) == i && creditCnt_q[i] >= CNT_W'(CREDITS)) begin
        creditOk = 1'b0;
      end
    end
    reqReady  = stageReady && creditOk;
    reqAccept = req_valid_i && reqReady;
    reqLoad   = reqAccept && reqLegal;

    stageValid_d = stageValid_q;
    stageChild_d = stageChild_q;
    stageData_d  = stageData_q;
    if (reqLoad) begin
      stageValid_d = 1'b1;
      stageChild_d = req_child_i;
      stageData_d  = req_data_i;
    end else if (stageReady) begin
      stageValid_d = 1'b0;
    end
  end

  always_comb begin
    child_valid_o = '0;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      child_valid_o[i] = stageValid_q && int'(stageChild_q) == i;
    end
  end

  // Scan downward from the pointer so the closest requester at or after it wins.
  always_comb begin
    int idx;
    idx        = 0;
    canGrant   = (!upValid_q || up_ready_i) && !rst;
    grantValid = 1'b0;
    grantIdx   = '0;
    for (int k = NUM_CHILDREN - 1; k >= 0; k--) begin
      idx = int'(rrPtr_q) + k;
      if (idx >= NUM_CHILDREN) begin
        idx = idx - NUM_CHILDREN;
      end
      if (rsp_valid_i[idx]) begin
        grantValid = 1'b1;
        grantIdx   = IDX_W'(idx);
      end
    end

    grantOneHot = '0;
    grantData   = '0;
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      grantOneHot[i] = canGrant && grantValid && int'(grantIdx) == i;
      if (int'(grantIdx) == i) begin
        grantData = rsp_data_i[i*DATA_W +: DATA_W];
      end
    end

    rrPtr_d   = rrPtr_q;
    upValid_d = upValid_q;
    upData_d  = upData_q;
    upChild_d = upChild_q;
    if (canGrant && grantValid) begin
      rrPtr_d   = (int'(grantIdx) == NUM_CHILDREN - 1) ? '0 : grantIdx + IDX_W'(1);
      upValid_d = 1'b1;
      upData_d  = grantData;
      upChild_d = grantIdx;
    end else if (up_ready_i) begin
      upValid_d = 1'b0;
    end
  end

  // A response with no credit outstanding still drains but flags an underflow.
  always_comb begin
    err_d     = err_q;
    anyCredit = 1'b0;
    incMask   = '0;
    if (reqAccept && !reqLegal) begin
      err_d[0] = 1'b1;
    end
    for (int i = 0; i < NUM_CHILDREN; i++) begin
      incMask[i]     = reqLoad && int'(req_child_i) == i;
      creditCnt_d[i] = creditCnt_q[i];
      anyCredit      = anyCredit || (creditCnt_q[i] != '0);
      if (grantOneHot[i] && creditCnt_q[i] == '0) begin
        err_d[1] = 1'b1;
      end
      if (incMask[i] && !grantOneHot[i]) begin
        creditCnt_d[i] = creditCnt_q[i] + CNT_W'(1);
      end else if (grantOneHot[i] && !incMask[i] && creditCnt_q[i] != '0) begin
        creditCnt_d[i] = creditCnt_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stageValid_q <= 1'b0;
      stageChild_q <= '0;
      stageData_q  <= '0;
      rrPtr_q      <= '0;
      upValid_q    <= 1'b0;
      upData_q     <= '0;
      upChild_q    <= '0;
      err_q        <= '0;
      for (int i = 0; i < NUM_CHILDREN; i++) begin
        creditCnt_q[i] <= '0;
      end
    end else begin
      stageValid_q <= stageValid_d;
      stageChild_q <= stageChild_d;
      stageData_q  <= stageData_d;
      rrPtr_q      <= rrPtr_d;
      upValid_q    <= upValid_d;
      upData_q     <= upData_d;
      upChild_q    <= upChild_d;
      err_q        <= err_d;
      for (int i = 0; i < NUM_CHILDREN; i++) begin
        creditCnt_q[i] <= creditCnt_d[i];
      end
    end
  end

  assign req_ready_o  = reqReady;
  assign child_data_o = stageData_q;
  assign rsp_ready_o  = grantOneHot;
  assign up_valid_o   = upValid_q;
  assign up_data_o    = upData_q;
  assign up_child_o   = upChild_q;
  assign busy_o       = anyCredit || stageValid_q || upValid_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_tree_node_dispatch.sv
`timescale 1ns/1ps
// Randomised scoreboard bench for tree_node_dispatch; children are modelled as response
// queues and the node is predicted at transaction level (credits, round-robin order, stage occupancy).
module tb_tree_node_dispatch;
  localparam int NUM = 5;
  localparam int DW  = 16;
  localparam int CR  = 4;
  localparam int IW  = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            reqValid, reqReady;
  logic [IW-1:0]   reqChild;
  logic [DW-1:0]   reqData;
  logic [NUM-1:0]  childValid, childReady;
  logic [DW-1:0]   childData;
  logic [NUM-1:0]  rspValid, rspReady;
  logic [NUM*DW-1:0] rspData;
  logic            upValid, upReady;
  logic [DW-1:0]   upData;
  logic [IW-1:0]   upChild;
  logic            busy;
  logic [1:0]      err;

  typedef struct packed {
    logic [7:0]    child;
    logic [DW-1:0] data;
  } item_t;

  item_t          expReqQ[$];
  item_t          expUpQ[$];
  logic [DW-1:0]  childRspQ[NUM][$];
  int             outstanding[NUM];
  int             rrPtr;
  int             stageChild;
  bit             stagePending;
  bit             upPending;
  logic [1:0]     errExp;
  int             reqProb, illegalProb, crProb, rspProb, upProb, spurProb;
  int             passCnt = 0;
  int             checkCnt = 0;
  bit             running = 1'b0;
  int             chIdx;

  always #10 clk = ~clk;

  tree_node_dispatch dut (
    .clk(clk), .rst(rst),
    .req_valid_i(reqValid), .req_ready_o(reqReady), .req_child_i(reqChild), .req_data_i(reqData),
    .child_valid_o(childValid), .child_ready_i(childReady), .child_data_o(childData),
    .rsp_valid_i(rspValid), .rsp_ready_o(rspReady), .rsp_data_i(rspData),
    .up_valid_o(upValid), .up_ready_i(upReady), .up_data_o(upData), .up_child_o(upChild),
    .busy_o(busy), .err_o(err)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checkCnt++;
    if (actual === expected) begin
      passCnt++;
    end else begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic clearModel();
    expReqQ.delete();
    expUpQ.delete();
    for (int i = 0; i < NUM; i++) outstanding[i] = 0;
    rrPtr = 0;
    stageChild = 0;
    stagePending = 1'b0;
    upPending = 1'b0;
    errExp = 2'b00;
  endtask

  task automatic setKnobs(input int rq, input int il, input int cr, input int rs, input int up, input int sp);
    reqProb = rq; illegalProb = il; crProb = cr; rspProb = rs; upProb = up; spurProb = sp;
  endtask

  task automatic applyStimulus();
    logic [NUM-1:0]    rv;
    logic [NUM*DW-1:0] rd;
    if (int'($urandom_range(99)) < spurProb) begin
      childRspQ[$urandom_range(NUM - 1)].push_back(DW'($urandom));
    end
    reqValid = (int'($urandom_range(99)) < reqProb);
    if (int'($urandom_range(99)) < illegalProb) reqChild = IW'($urandom_range(7, NUM));
    else reqChild = IW'($urandom_range(NUM - 1));
    reqData = DW'($urandom);
    rv = '0;
    rd = '0;
    for (int i = 0; i < NUM; i++) begin
      childReady[i] = (int'($urandom_range(99)) < crProb);
      if (childRspQ[i].size() > 0) begin
        rd[i*DW +: DW] = childRspQ[i][0];
        rv[i] = (int'($urandom_range(99)) < rspProb);
      end else begin
        rd[i*DW +: DW] = DW'($urandom);
      end
    end
    rspValid = rv;
    rspData  = rd;
    upReady  = (int'($urandom_range(99)) < upProb);
  endtask

  task automatic runPhase(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      applyStimulus();
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_child_valid"}, 64'(childValid), 64'(0));
    checkOutput({tag, "_child_data"}, 64'(childData), 64'(0));
    checkOutput({tag, "_rsp_ready"}, 64'(rspReady), 64'(0));
    checkOutput({tag, "_up_valid"}, 64'(upValid), 64'(0));
    checkOutput({tag, "_up_data"}, 64'(upData), 64'(0));
    checkOutput({tag, "_up_child"}, 64'(upChild), 64'(0));
    checkOutput({tag, "_busy"}, 64'(busy), 64'(0));
    checkOutput({tag, "_err"}, 64'(err), 64'(0));
  endtask

  // One transaction-level step per cycle: predict handshakes, then advance as the clock edge would.
  task automatic modelStep();
    logic [NUM-1:0] expCv, expRr;
    bit  delivered, legal, acceptOk, accept, canGrant, granted, busyExp, inc, dec;
    int  c, g, idx;
    expCv = '0;
    if (stagePending) expCv[stageChild] = 1'b1;
    busyExp = stagePending || upPending;
    for (int i = 0; i < NUM; i++) if (outstanding[i] > 0) busyExp = 1'b1;
    checkOutput("child_valid", 64'(childValid), 64'(expCv));
    checkOutput("up_valid", 64'(upValid), 64'(upPending));
    checkOutput("busy", 64'(busy), 64'(busyExp));
    checkOutput("err", 64'(err), 64'(errExp));

    c = int'(reqChild);
    legal = (c < NUM);
    delivered = stagePending && childReady[stageChild];
    acceptOk = (!stagePending || delivered) && (!legal || outstanding[legal ? c : 0] < CR);
    checkOutput("req_ready", 64'(reqReady), 64'(acceptOk));
    accept = acceptOk && reqValid;

    canGrant = !upPending || upReady;
    granted = 1'b0;
    g = 0;
    if (canGrant) begin
      for (int k = 0; k < NUM; k++) begin
        idx = (rrPtr + k) % NUM;
        if (!granted && rspValid[idx]) begin
          granted = 1'b1;
          g = idx;
        end
      end
    end
    expRr = '0;
    if (granted) expRr[g] = 1'b1;
    checkOutput("rsp_ready", 64'(rspReady), 64'(expRr));

    if (delivered) begin
      if (expReqQ.size() > 0) childRspQ[stageChild].push_back(expReqQ[0].data ^ 16'hC3C3);
      stagePending = 1'b0;
    end
    if (accept) begin
      if (legal) begin
        expReqQ.push_back('{child: 8'(c), data: reqData});
        stagePending = 1'b1;
        stageChild = c;
      end else begin
        errExp[0] = 1'b1;
      end
    end
    for (int i = 0; i < NUM; i++) begin
      inc = accept && legal && c == i;
      dec = granted && g == i;
      if (dec && outstanding[i] == 0) errExp[1] = 1'b1;
      if (inc && !dec) outstanding[i]++;
      else if (dec && !inc && outstanding[i] > 0) outstanding[i]--;
    end
    if (granted) begin
      expUpQ.push_back('{child: 8'(g), data: childRspQ[g][0]});
      childRspQ[g].pop_front();
      rrPtr = (g + 1) % NUM;
      upPending = 1'b1;
    end else if (upReady) begin
      upPending = 1'b0;
    end
  endtask

  initial forever begin
    @(negedge clk);
    #2;
    if (running && !rst) modelStep();
  end

  // Child-side monitor: whatever the stage presents must be the oldest accepted legal request.
  initial forever begin
    @(negedge clk);
    #3;
    if (running && !rst && childValid != '0) begin
      chIdx = 0;
      for (int i = 0; i < NUM; i++) if (childValid[i]) chIdx = i;
      if (expReqQ.size() == 0) begin
        checkOutput("child_unexpected", 64'(childValid), 64'(0));
      end else begin
        checkOutput("child_idx", 64'(chIdx), 64'(expReqQ[0].child));
        checkOutput("child_data", 64'(childData), 64'(expReqQ[0].data));
        if (childReady[chIdx]) void'(expReqQ.pop_front());
      end
    end
  end

  // Upstream monitor: the output register must show the oldest granted response until drained.
  initial forever begin
    @(negedge clk);
    #3;
    if (running && !rst && upValid) begin
      if (expUpQ.size() == 0) begin
        checkOutput("up_unexpected", 64'(upValid), 64'(0));
      end else begin
        checkOutput("up_child", 64'(upChild), 64'(expUpQ[0].child));
        checkOutput("up_data", 64'(upData), 64'(expUpQ[0].data));
        if (upReady) void'(expUpQ.pop_front());
      end
    end
  end

  initial begin
    reqValid = 1'b0; reqChild = '0; reqData = '0; childReady = '0;
    rspValid = '0; rspData = '0; upReady = 1'b0;
    setKnobs(0, 0, 0, 0, 0, 0);
    clearModel();
    repeat (3) @(negedge clk);
    #1;
    checkReset("init");
    rst = 1'b0;
    running = 1'b1;

    $display("[TB] mixed traffic");
    setKnobs(50, 0, 80, 70, 80, 0);
    runPhase(200);

    $display("[TB] full-rate traffic");
    setKnobs(100, 0, 100, 100, 100, 0);
    runPhase(100);

    $display("[TB] credit exhaustion");
    setKnobs(100, 0, 100, 0, 100, 0);
    runPhase(40);
    setKnobs(60, 0, 100, 100, 100, 0);
    runPhase(40);

    $display("[TB] upstream back-pressure");
    setKnobs(70, 0, 90, 100, 20, 0);
    runPhase(120);

    $display("[TB] asynchronous reset mid-traffic");
    setKnobs(100, 0, 50, 50, 30, 0);
    runPhase(10);
    @(negedge clk);
    applyStimulus();
    #5;
    rst = 1'b1;
    #1;
    checkReset("midrst");
    clearModel();
    @(negedge clk);
    applyStimulus();
    @(negedge clk);
    applyStimulus();
    #1;
    rst = 1'b0;

    $display("[TB] illegal targets and unsolicited responses");
    setKnobs(60, 15, 80, 80, 80, 10);
    runPhase(150);

    $display("[TB] drain");
    setKnobs(0, 0, 100, 100, 100, 0);
    runPhase(80);
    @(negedge clk);
    #4;
    checkOutput("reqq_drained", 64'(expReqQ.size()), 64'(0));
    checkOutput("upq_drained", 64'(expUpQ.size()), 64'(0));

    $display("%0d/%0d checks passed", passCnt, checkCnt);
    $finish;
  end

endmodule

// File: doc/tree_node_dispatch.md
# tree_node_dispatch

Parametrised fan-out/fan-in node for the generated module tree. It routes upstream requests to one of NUM_CHILDREN child instances, limits the outstanding requests per child with credit counters, and round-robin arbitrates child responses back upstream. It generalises the fixed five-child hierarchy node into a node with a configurable child count and real request/response traffic, and serves as the standard interior node of every generated tree level.

## Interface
- NUM_CHILDREN, 5, number of child ports; legal range 2..64.
- DATA_W, 16, payload width for requests and responses.
- CREDITS, 4, maximum outstanding requests per child; legal range 1..15.
- IDX_W, $clog2(NUM_CHILDREN), derived; child index width.
- CNT_W, $clog2(CREDITS+1), derived; credit counter width.

Ports:
- clk  in  1  single clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  upstream request valid.
- req_ready  out  1  upstream request accepted when req_valid is high in the same cycle.
- req_child  in  IDX_W  target child index.
- req_data  in  DATA_W  request payload.
- child_valid  out  NUM_CHILDREN  one-hot request valid to the children.
- child_ready  in  NUM_CHILDREN  per-child request ready.
- child_data  out  DATA_W  shared request payload bus.
- rsp_valid  in  NUM_CHILDREN  per-child response valid.
- rsp_ready  out  NUM_CHILDREN  per-child response accept; one-hot or zero.
- rsp_data  in  NUM_CHILDREN*DATA_W  child i response in bits [i*DATA_W +: DATA_W].
- up_valid  out  1  upstream response valid.
- up_ready  in  1  upstream response ready.
- up_data  out  DATA_W  upstream response payload.
- up_child  out  IDX_W  index of the responding child.
- busy  out  1  high when any credit counter is nonzero or a stage register is full.
- err  out  2  sticky error flags: bit0 = illegal index, bit1 = credit underflow.

## Operation
- Dispatch stage: a single register holding {valid, child, data}. child_valid[i] = stage_valid && stage_child == i. child_data = stage_data.
- req_ready = !stage_valid || child_ready[stage_child], AND the credit count of the target child (req_child) is below CREDITS. An illegal req_child (>= NUM_CHILDREN) ignores the credit term.
- Request with an illegal index: it is accepted and dropped (the stage is not loaded), and err[0] is set.
- Credit counter i: increments when a request to child i loads the stage. It decrements when a child i response is accepted (rsp_valid[i] && rsp_ready[i]). If both happen in the same cycle, the counter is unchanged.
- Response accepted while counter i == 0: the response is still forwarded, the counter stays 0, and err[1] is set.
- Response arbiter: round-robin over rsp_valid. The priority pointer resets to 0. After a grant to child g, the pointer becomes (g+1) mod NUM_CHILDREN. The arbiter grants only when the output register is empty or is draining in the same cycle (up_ready && up_valid).
- Output register: on a grant it loads {rsp_data slice, g} and up_valid rises. It holds stable while up_valid && !up_ready.
- err bits clear only on rst.

## Timing
- Reset values: child_valid=0, child_data=0, rsp_ready=0, up_valid=0, up_data=0, up_child=0, busy=0, err=0. All counters are 0 and the pointer is 0.
- Request latency: accepted at edge t, child_valid[target] is high in cycle t+1. The full rate is 1 request/cycle while the child keeps child_ready high.
- Response latency: granted at edge t, up_valid is high in cycle t+1. The full rate is 1 response/cycle while up_ready is held high.
- A stalled child (child_ready low) holds child_valid and child_data stable.
- A full-credit target blocks req_ready even if the stage is empty.
- An asynchronous rst mid-transfer immediately clears all stages and counters. In-flight requests are lost, and responses arriving after reset trigger the underflow behaviour.

## Test plan
- Reset, then single request child=2, data=0x1234, child_ready=1: child_valid=5'b00100 and child_data=0x1234 one cycle after acceptance, busy=1. Child 2 responds 0xBEEF: up_valid one cycle later with up_child=2, up_data=0xBEEF, busy returns to 0.
- Send 4 requests to child 1 with no responses (CREDITS=4): the 5th request sees req_ready=0. One response from child 1 is accepted, and req_ready rises the next cycle.
- All 5 children assert rsp_valid continuously with up_ready=1: grants go in order 0,1,2,3,4,0 with one per cycle.
- up_ready held low for 3 cycles while a response is pending: up_data and up_child stay stable, and no rsp_ready is asserted until the drain.
- Request with req_child=7 (NUM_CHILDREN=5): it is accepted, no child_valid, err=2'b01. Then a child 3 response arrives with its counter at 0: it is forwarded, and err=2'b11.
- rst asserted while 2 requests are outstanding: all outputs drop to their reset values without waiting for a clock edge.
